// File: rtl/mem_arbiter_if.sv
// Word-addressed simple memory bus shared by the two masters and the slave.
// Handshake: the master raises re and/or any bit of we together with addr and
// wdata, and holds all of them stable until it sees ready=1 for one cycle.
// rdata is valid only in that ready cycle. There is no separate valid signal.
// A request is in progress whenever (re | |we) is high.
// Modport "master" is the side that issues requests.
// Modport "slave" is the side that answers them.
interface mem_arbiter_if #(
  parameter int AW = 30,
  parameter int DW = 32
) ();
  logic            re;
  logic [DW/8-1:0] we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic            ready;

  modport master (output re, output we, output addr, output wdata,
                  input rdata, input ready);
  modport slave  (input re, input we, input addr, input wdata,
                  output rdata, output ready);
endinterface

// File: rtl/mem_arbiter.sv
// Two-master, one-slave arbiter for the simple memory bus.
// Port 0 (CPU) and port 1 (DMA/debug loader) share one slave.
// The granted request is registered onto the slave and held until s.ready.
// The slave's read data then goes back to the winner, registered, together
// with a one-cycle ready pulse.
// Optional feature macro: ARB_ROUND_ROBIN_EN.
//   Defined:   ties alternate through a 1-bit preferred-port pointer.
//   Undefined: fixed priority, port 0 wins every tie.
// The FSM state is exported on o_dbg_state (0=IDLE, 1=ISSUE, 2=RESP).
module mem_arbiter #(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic          busy,
  output logic          grant,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_s_re;
  logic [DW/8-1:0] r_s_we;
  logic [AW-1:0]   r_s_addr;
  logic [DW-1:0]   r_s_wdata;
  logic [DW-1:0]   r_m0_rdata;
  logic [DW-1:0]   r_m1_rdata;
  logic            r_m0_ready;
  logic            r_m1_ready;
  logic            r_busy;
  logic            r_grant;

  logic            w_m0_req;
  logic            w_m1_req;
  logic            w_pick;   // 1 selects port 1 when a grant is made

  assign w_m0_req = m0.re | (|m0.we);
  assign w_m1_req = m1.re | (|m1.we);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr;  // preferred port for the next tie

  // Ties follow the pointer; a lone requester always wins
  always_comb begin
    w_pick = ~w_m0_req;
    if (w_m0_req && w_m1_req) w_pick = r_ptr;
  end

  // After every grant, prefer the port that lost (or did not ask)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 1'b0;
    end else if (r_state == ST_IDLE && (w_m0_req || w_m1_req)) begin
      r_ptr <= ~w_pick;
    end
  end
`else
  // Fixed priority: port 1 only when port 0 is not requesting
  assign w_pick = ~w_m0_req;
`endif

  // Arbitration FSM with every bus-facing output registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_s_re     <= 1'b0;
      r_s_we     <= '0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_grant    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_m0_req || w_m1_req) begin
            r_grant   <= w_pick;
            r_s_re    <= w_pick ? m1.re    : m0.re;
            r_s_we    <= w_pick ? m1.we    : m0.we;
            r_s_addr  <= w_pick ? m1.addr  : m0.addr;
            r_s_wdata <= w_pick ? m1.wdata : m0.wdata;
            r_busy    <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The read data register only moves on a read; writes leave it alone
          if (s.ready) begin
            if (r_s_re) begin
              if (r_grant) r_m1_rdata <= s.rdata;
              else         r_m0_rdata <= s.rdata;
            end
            r_m0_ready <= ~r_grant;
            r_m1_ready <= r_grant;
            r_s_re     <= 1'b0;
            r_s_we     <= '0;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Requests are not sampled here, so the winner's held request is not re-granted
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s.re        = r_s_re;
  assign s.we        = r_s_we;
  assign s.addr      = r_s_addr;
  assign s.wdata     = r_s_wdata;
  assign m0.rdata    = r_m0_rdata;
  assign m0.ready    = r_m0_ready;
  assign m1.rdata    = r_m1_rdata;
  assign m1.ready    = r_m1_ready;
  assign busy        = r_busy;
  assign grant       = r_grant;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter.
// Inputs are driven, and registered outputs sampled, 1 time unit after each rising edge.
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       busy;
  logic       grant;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_p;
  int          k;

  mem_arbiter_if #(.AW(30), .DW(32)) m0_if ();
  mem_arbiter_if #(.AW(30), .DW(32)) m1_if ();
  mem_arbiter_if #(.AW(30), .DW(32)) s_if ();

  mem_arbiter #(.AW(30), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_if.slave),
    .m1          (m1_if.slave),
    .s           (s_if.master),
    .busy        (busy),
    .grant       (grant),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input bit port, input logic re, input logic [3:0] we,
                         input logic [29:0] addr, input logic [31:0] wdata);
    if (port) begin
      m1_if.re = re; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    end else begin
      m0_if.re = re; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_m(0, 1'b0, 4'h0, 30'h0, 32'h0);
    drive_m(1, 1'b0, 4'h0, 30'h0, 32'h0);
    s_if.rdata = 32'h0;
    s_if.ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_state", dbg_state, 0);
    check("rst_s_re", s_if.re, 0);
    check("rst_s_we", s_if.we, 0);
    check("rst_s_addr", s_if.addr, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_m0_rdata", m0_if.rdata, 0);
    reset = 1'b1;
    step();

    // m0 read at 0x10, slave answers two cycles after s_re
    drive_m(0, 1'b1, 4'h0, 30'h10, 32'h0);
    step();
    check("rd_s_re", s_if.re, 1);
    check("rd_s_addr", s_if.addr, 30'h10);
    check("rd_busy", busy, 1);
    check("rd_grant", grant, 0);
    check("rd_state", dbg_state, 1);
    step();
    check("rd_no_ready_yet", m0_if.ready, 0);
    step();
    s_if.rdata = 32'hDEADBEEF;
    s_if.ready = 1'b1;
    step();
    s_if.ready = 1'b0;
    s_if.rdata = 32'h0;
    check("rd_m0_ready", m0_if.ready, 1);
    check("rd_m0_rdata", m0_if.rdata, 32'hDEADBEEF);
    check("rd_m1_ready", m1_if.ready, 0);
    check("rd_s_re_clr", s_if.re, 0);
    // m0 keeps its request through the ready cycle and drops it only now
    step();
    drive_m(0, 1'b0, 4'h0, 30'h0, 32'h0);
    check("hold_no_reissue", s_if.re, 0);
    check("hold_m0_ready_pulse", m0_if.ready, 0);
    check("hold_state_idle", dbg_state, 0);
    check("hold_busy", busy, 0);
    step();
    check("hold_still_idle", s_if.re, 0);
    check("hold_rdata_kept", m0_if.rdata, 32'hDEADBEEF);

    // m1 write we=0011 addr 0x3FF
    drive_m(1, 1'b0, 4'b0011, 30'h3FF, 32'h12345678);
    step();
    check("wr_s_we", s_if.we, 4'b0011);
    check("wr_s_addr", s_if.addr, 30'h3FF);
    check("wr_s_wdata", s_if.wdata, 32'h12345678);
    check("wr_s_re", s_if.re, 0);
    check("wr_grant", grant, 1);
    step();
    check("wr_s_we_held", s_if.we, 4'b0011);
    check("wr_s_wdata_held", s_if.wdata, 32'h12345678);
    s_if.rdata = 32'hBAD0BAD0;
    s_if.ready = 1'b1;
    step();
    s_if.ready = 1'b0;
    drive_m(1, 1'b0, 4'h0, 30'h0, 32'h0);
    check("wr_m1_ready", m1_if.ready, 1);
    check("wr_m1_rdata_kept", m1_if.rdata, 0);
    check("wr_m0_ready", m0_if.ready, 0);
    check("wr_m0_rdata_kept", m0_if.rdata, 32'hDEADBEEF);
    check("wr_s_we_clr", s_if.we, 0);
    step();
    step();

    // s_ready while IDLE is ignored
    s_if.rdata = 32'h55555555;
    s_if.ready = 1'b1;
    step();
    s_if.ready = 1'b0;
    step();
    check("idle_rdy_m0", m0_if.ready, 0);
    check("idle_rdy_m1", m1_if.ready, 0);
    check("idle_rdy_m0_rdata", m0_if.rdata, 32'hDEADBEEF);
    check("idle_rdy_m1_rdata", m1_if.rdata, 0);
    check("idle_rdy_state", dbg_state, 0);

    // Reset asserted mid-ISSUE clears outputs without waiting for a clock
    drive_m(0, 1'b1, 4'hF, 30'h20, 32'hCAFEF00D);
    step();
    check("mid_s_re", s_if.re, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_s_re", s_if.re, 0);
    check("mid_rst_s_we", s_if.we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_m0_ready", m0_if.ready, 0);
    check("mid_rst_m1_ready", m1_if.ready, 0);
    check("mid_rst_m0_rdata", m0_if.rdata, 0);
    step();
    drive_m(0, 1'b0, 4'h0, 30'h0, 32'h0);
    reset = 1'b1;
    step();
    check("mid_rel_state", dbg_state, 0);
    check("mid_rel_s_re", s_if.re, 0);

    // Both ports request continuously for four transactions
`ifdef ARB_ROUND_ROBIN_EN
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
`else
    exp_q = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    drive_m(0, 1'b1, 4'h0, 30'h100, 32'h0);
    drive_m(1, 1'b1, 4'h0, 30'h200, 32'h0);
    for (int t = 0; t < 4; t++) begin
      k = 0;
      while (s_if.re !== 1'b1 && k < 10) begin
        step();
        k++;
      end
      check("both_issue_seen", {31'h0, s_if.re}, 1);
      exp_p = exp_q.pop_front();
      check("both_grant", grant, exp_p);
      check("both_addr", s_if.addr, (exp_p == 0) ? 30'h100 : 30'h200);
      s_if.rdata = 32'hA0 + t;
      s_if.ready = 1'b1;
      step();
      s_if.ready = 1'b0;
      check("both_ready", (exp_p == 0) ? m0_if.ready : m1_if.ready, 1);
      check("both_other_ready", (exp_p == 0) ? m1_if.ready : m0_if.ready, 0);
      check("both_rdata", (exp_p == 0) ? m0_if.rdata : m1_if.rdata, 32'hA0 + t);
    end
    drive_m(0, 1'b0, 4'h0, 30'h0, 32'h0);
    drive_m(1, 1'b0, 4'h0, 30'h0, 32'h0);
    step();
    step();
    check("end_busy", busy, 0);
    check("end_state", dbg_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
